// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : hazard_controller
// Description : Pipeline interlock and operand-forwarding controller for a
//               4-stage CPU (D, EX, MEM, WB). A shadow pipeline holds the
//               destination info of the instructions in EX, MEM and WB. The
//               decode-stage read selectors are compared against it to
//               produce stall / EX-bubble control and EX operand selects.
// Build macro : HAZARD_FORWARDING_EN
//               defined   -> forwarding from EX/MEM/WB, stall only on load-use
//               undefined -> no forwarding, stall until the writer retires
// Parameters  : SEL_W        register selector width
//               CNT_W        stall performance counter width
//               R0_HARDWIRED 1: selector 0 never hazards or forwards
// Ports       : i_clk, i_reset (async, active-high)
//               i_d_valid/re1/rs1/re2/rs2/we/ws/is_load  decode instruction
//               i_flush      squash the decode instruction
//               i_mem_wait   freeze the whole pipeline this cycle
//               o_stall      hold PC and D register
//               o_bubble_ex  load a NOP into EX
//               o_fwd1/2     EX operand source: 0 regfile, 1 EX, 2 MEM, 3 WB
//               o_stall_cnt  saturating hazard-stall cycle count
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_controller #(
    parameter int SEL_W        = 4,
    parameter int CNT_W        = 16,
    parameter int R0_HARDWIRED = 0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_d_valid,
    input  logic             i_d_re1,
    input  logic [SEL_W-1:0] i_d_rs1,
    input  logic             i_d_re2,
    input  logic [SEL_W-1:0] i_d_rs2,
    input  logic             i_d_we,
    input  logic [SEL_W-1:0] i_d_ws,
    input  logic             i_d_is_load,
    input  logic             i_flush,
    input  logic             i_mem_wait,
    output logic             o_stall,
    output logic             o_bubble_ex,
    output logic [1:0]       o_fwd1,
    output logic [1:0]       o_fwd2,
    output logic [CNT_W-1:0] o_stall_cnt
);

    // Shadow destination info for the instructions in EX, MEM and WB
    logic             r_ex_valid, r_ex_we;
    logic [SEL_W-1:0] r_ex_ws;
    logic             r_mem_valid, r_mem_we;
    logic [SEL_W-1:0] r_mem_ws;
    logic             r_wb_valid, r_wb_we;
    logic [SEL_W-1:0] r_wb_ws;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_ex_hit1, w_mem_hit1, w_wb_hit1;
    logic w_ex_hit2, w_mem_hit2, w_wb_hit2;
    logic w_hazard;
    logic w_advance;
    logic w_count;

    function automatic logic f_match(input logic             v,
                                     input logic             we,
                                     input logic [SEL_W-1:0] ws,
                                     input logic [SEL_W-1:0] s);
        f_match = v & we & (ws == s) & ~((R0_HARDWIRED != 0) && (s == '0));
    endfunction

    assign w_ex_hit1  = i_d_re1 & f_match(r_ex_valid,  r_ex_we,  r_ex_ws,  i_d_rs1);
    assign w_mem_hit1 = i_d_re1 & f_match(r_mem_valid, r_mem_we, r_mem_ws, i_d_rs1);
    assign w_wb_hit1  = i_d_re1 & f_match(r_wb_valid,  r_wb_we,  r_wb_ws,  i_d_rs1);
    assign w_ex_hit2  = i_d_re2 & f_match(r_ex_valid,  r_ex_we,  r_ex_ws,  i_d_rs2);
    assign w_mem_hit2 = i_d_re2 & f_match(r_mem_valid, r_mem_we, r_mem_ws, i_d_rs2);
    assign w_wb_hit2  = i_d_re2 & f_match(r_wb_valid,  r_wb_we,  r_wb_ws,  i_d_rs2);

`ifdef HAZARD_FORWARDING_EN
    // Only EX needs to remember loads: a load in MEM or WB has its data ready.
    logic r_ex_ld;

    function automatic logic [1:0] f_sel(input logic ex, input logic mem, input logic wb);
        // Youngest producer holds the architecturally newest value.
        if (ex)       f_sel = 2'd1;
        else if (mem) f_sel = 2'd2;
        else if (wb)  f_sel = 2'd3;
        else          f_sel = 2'd0;
    endfunction

    assign w_hazard = i_d_valid & r_ex_ld & (w_ex_hit1 | w_ex_hit2);
    assign o_fwd1   = f_sel(w_ex_hit1, w_mem_hit1, w_wb_hit1);
    assign o_fwd2   = f_sel(w_ex_hit2, w_mem_hit2, w_wb_hit2);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ex_ld <= 1'b0;
        end else if (w_advance) begin
            r_ex_ld <= (w_hazard | i_flush) ? 1'b0 : i_d_is_load;
        end
    end
`else
    // Without forwarding every in-flight writer blocks the reader.
    logic w_unused_is_load;

    assign w_hazard = i_d_valid & (w_ex_hit1 | w_mem_hit1 | w_wb_hit1 |
                                   w_ex_hit2 | w_mem_hit2 | w_wb_hit2);
    assign o_fwd1   = 2'd0;
    assign o_fwd2   = 2'd0;
    assign w_unused_is_load = i_d_is_load;
`endif

    // Memory wait freezes everything and outranks flush and hazards.
    assign w_advance   = ~i_mem_wait;
    assign w_count     = w_advance & w_hazard & ~i_flush;
    assign o_stall     = i_mem_wait | (w_hazard & ~i_flush);
    assign o_bubble_ex = w_advance & (i_flush | w_hazard);
    assign o_stall_cnt = r_stall_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ex_valid  <= 1'b0;
            r_ex_we     <= 1'b0;
            r_ex_ws     <= '0;
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_ws    <= '0;
            r_wb_valid  <= 1'b0;
            r_wb_we     <= 1'b0;
            r_wb_ws     <= '0;
        end else if (w_advance) begin
            r_wb_valid  <= r_mem_valid;
            r_wb_we     <= r_mem_we;
            r_wb_ws     <= r_mem_ws;
            r_mem_valid <= r_ex_valid;
            r_mem_we    <= r_ex_we;
            r_mem_ws    <= r_ex_ws;
            if (w_hazard | i_flush) begin
                r_ex_valid <= 1'b0;
                r_ex_we    <= 1'b0;
                r_ex_ws    <= '0;
            end else begin
                r_ex_valid <= i_d_valid;
                r_ex_we    <= i_d_we;
                r_ex_ws    <= i_d_ws;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_stall_cnt <= '0;
        end else if (w_count && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_controller
// Description : Self-checking bench for hazard_controller. Two instances share
//               the stimulus: u_a (defaults) and u_b (R0_HARDWIRED=1, CNT_W=2).
//               Works with HAZARD_FORWARDING_EN defined or undefined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_controller;

`ifdef HAZARD_FORWARDING_EN
    localparam bit c_fwd = 1'b1;
`else
    localparam bit c_fwd = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       d_valid, d_re1, d_re2, d_we, d_is_load, flush, mem_wait;
    logic [3:0] d_rs1, d_rs2, d_ws;

    logic        a_stall, a_bubble, b_stall, b_bubble;
    logic [1:0]  a_fwd1, a_fwd2, b_fwd1, b_fwd2;
    logic [15:0] a_cnt;
    logic [1:0]  b_cnt;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    hazard_controller u_a (
        .i_clk(clk), .i_reset(reset), .i_d_valid(d_valid),
        .i_d_re1(d_re1), .i_d_rs1(d_rs1), .i_d_re2(d_re2), .i_d_rs2(d_rs2),
        .i_d_we(d_we), .i_d_ws(d_ws), .i_d_is_load(d_is_load),
        .i_flush(flush), .i_mem_wait(mem_wait),
        .o_stall(a_stall), .o_bubble_ex(a_bubble),
        .o_fwd1(a_fwd1), .o_fwd2(a_fwd2), .o_stall_cnt(a_cnt)
    );

    hazard_controller #(.SEL_W(4), .CNT_W(2), .R0_HARDWIRED(1)) u_b (
        .i_clk(clk), .i_reset(reset), .i_d_valid(d_valid),
        .i_d_re1(d_re1), .i_d_rs1(d_rs1), .i_d_re2(d_re2), .i_d_rs2(d_rs2),
        .i_d_we(d_we), .i_d_ws(d_ws), .i_d_is_load(d_is_load),
        .i_flush(flush), .i_mem_wait(mem_wait),
        .o_stall(b_stall), .o_bubble_ex(b_bubble),
        .o_fwd1(b_fwd1), .o_fwd2(b_fwd2), .o_stall_cnt(b_cnt)
    );

    // ------------------------------------------------------------------
    // Reference model: per instance, a list of in-flight writers ordered
    // by age (0 = EX, 1 = MEM, 2 = WB).
    // ------------------------------------------------------------------
    typedef struct packed {
        bit       v;
        bit       we;
        bit [3:0] ws;
        bit       ld;
    } ent_t;

    ent_t        sh [2][3];
    int unsigned mcnt [2];
    int unsigned cmax [2] = '{65535, 3};
    bit          r0h  [2] = '{1'b0, 1'b1};

    function automatic bit writes(int k, int age, bit [3:0] s);
        return sh[k][age].v && sh[k][age].we && sh[k][age].ws == s && !(r0h[k] && s == 4'd0);
    endfunction

    function automatic bit blocks(int k, bit re, bit [3:0] s);
        if (!re) return 1'b0;
        if (c_fwd) return writes(k, 0, s) && sh[k][0].ld;
        for (int a = 0; a < 3; a++)
            if (writes(k, a, s)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_haz(int k);
        return d_valid && (blocks(k, d_re1, d_rs1) || blocks(k, d_re2, d_rs2));
    endfunction

    function automatic logic [1:0] m_fwd(int k, bit re, bit [3:0] s);
        if (!c_fwd || !re) return 2'd0;
        for (int a = 0; a < 3; a++)
            if (writes(k, a, s)) return 2'(a + 1);
        return 2'd0;
    endfunction

    function automatic bit m_stall(int k);
        if (mem_wait) return 1'b1;
        if (flush)    return 1'b0;
        return m_haz(k);
    endfunction

    function automatic bit m_bubble(int k);
        if (mem_wait) return 1'b0;
        return flush || m_haz(k);
    endfunction

    task automatic mdl_reset();
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 3; a++) sh[k][a] = '0;
            mcnt[k] = 0;
        end
    endtask

    task automatic mdl_clock();
        for (int k = 0; k < 2; k++) begin
            if (!mem_wait) begin
                bit h;
                h = m_haz(k);
                if (h && !flush && mcnt[k] < cmax[k]) mcnt[k]++;
                sh[k][2] = sh[k][1];
                sh[k][1] = sh[k][0];
                if (h || flush) sh[k][0] = '0;
                else sh[k][0] = '{v: d_valid, we: d_we, ws: d_ws, ld: d_is_load};
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("a_stall",  32'(a_stall),  32'(m_stall(0)));
        chk("a_bubble", 32'(a_bubble), 32'(m_bubble(0)));
        chk("a_fwd1",   32'(a_fwd1),   32'(m_fwd(0, d_re1, d_rs1)));
        chk("a_fwd2",   32'(a_fwd2),   32'(m_fwd(0, d_re2, d_rs2)));
        chk("a_cnt",    32'(a_cnt),    mcnt[0]);
        chk("b_stall",  32'(b_stall),  32'(m_stall(1)));
        chk("b_bubble", 32'(b_bubble), 32'(m_bubble(1)));
        chk("b_fwd1",   32'(b_fwd1),   32'(m_fwd(1, d_re1, d_rs1)));
        chk("b_fwd2",   32'(b_fwd2),   32'(m_fwd(1, d_re2, d_rs2)));
        chk("b_cnt",    32'(b_cnt),    mcnt[1]);
    endtask

    typedef struct packed {
        bit       valid;
        bit       re1;
        bit [3:0] rs1;
        bit       re2;
        bit [3:0] rs2;
        bit       we;
        bit [3:0] ws;
        bit       ld;
        bit       fl;
        bit       mw;
    } in_t;

    function automatic in_t mk(bit v, bit r1, bit [3:0] s1, bit r2, bit [3:0] s2,
                               bit w, bit [3:0] ws, bit ld, bit fl, bit mw);
        return '{valid: v, re1: r1, rs1: s1, re2: r2, rs2: s2,
                 we: w, ws: ws, ld: ld, fl: fl, mw: mw};
    endfunction

    // Drive at the falling edge, settle, outputs are then sampleable.
    task automatic drive(in_t x);
        @(negedge clk);
        d_valid = x.valid; d_re1 = x.re1; d_rs1 = x.rs1; d_re2 = x.re2; d_rs2 = x.rs2;
        d_we = x.we; d_ws = x.ws; d_is_load = x.ld; flush = x.fl; mem_wait = x.mw;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        mdl_clock();
    endtask

    task automatic run_cycle(in_t x);
        drive(x);
        check_model();
        tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        mdl_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        in_t        in;
        logic [5:0] exp_f;   // {stall, bubble, fwd1, fwd2} with forwarding
        int         cnt_f;
        logic [5:0] exp_n;   // same, without forwarding
        int         cnt_n;
    } vec_t;

    vec_t vecs [13];

    initial begin
        in_t nop, add_r2, sub_r5;
        logic [5:0] got;
        reset = 1'b1;
        nop = mk(0,0,0,0,0,0,0,0,0,0);
        d_valid = 0; d_re1 = 0; d_rs1 = 0; d_re2 = 0; d_rs2 = 0;
        d_we = 0; d_ws = 0; d_is_load = 0; flush = 0; mem_wait = 0;
        mdl_reset();
        repeat (2) @(negedge clk);

        // Reset state
        #1;
        chk("reset_a_stall", 32'(a_stall), 0);
        chk("reset_a_fwd1",  32'(a_fwd1),  0);
        chk("reset_a_cnt",   32'(a_cnt),   0);
        reset = 1'b0;

        // ---------------- table-driven sequence ----------------
        add_r2 = mk(1,1,4'd1,1,4'd1,1,4'd2,0,0,0);   // ADD r2,r1,r1
        sub_r5 = mk(1,1,4'd4,1,4'd6,1,4'd5,0,0,0);   // SUB r5,r4,r6
        vecs[0]  = '{mk(1,1,4'd2,1,4'd3,1,4'd1,0,0,0), 6'b000000, 0, 6'b000000, 0};
        vecs[1]  = '{add_r2,                          6'b000101, 0, 6'b110000, 0};
        vecs[2]  = '{add_r2,                          6'b001010, 0, 6'b110000, 1};
        vecs[3]  = '{add_r2,                          6'b001111, 0, 6'b110000, 2};
        vecs[4]  = '{add_r2,                          6'b000000, 0, 6'b000000, 3};
        vecs[5]  = '{nop,                             6'b000000, 0, 6'b000000, 3};
        vecs[6]  = '{mk(1,1,4'd7,0,0,1,4'd4,1,0,0),   6'b000000, 0, 6'b000000, 3};
        vecs[7]  = '{mk(1,1,4'd4,1,4'd6,1,4'd5,0,0,1), 6'b100100, 0, 6'b100000, 3};
        vecs[8]  = '{mk(1,1,4'd4,1,4'd6,1,4'd5,0,0,1), 6'b100100, 0, 6'b100000, 3};
        vecs[9]  = '{sub_r5,                          6'b110100, 0, 6'b110000, 3};
        vecs[10] = '{sub_r5,                          6'b001000, 1, 6'b110000, 4};
        vecs[11] = '{mk(1,1,4'd4,1,4'd6,1,4'd5,0,1,0), 6'b011100, 1, 6'b010000, 5};
        vecs[12] = '{nop,                             6'b000000, 1, 6'b000000, 5};

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].in);
            got = {a_stall, a_bubble, a_fwd1, a_fwd2};
            chk($sformatf("vec%0d_ctl", i), 32'(got), 32'(c_fwd ? vecs[i].exp_f : vecs[i].exp_n));
            chk($sformatf("vec%0d_cnt", i), 32'(a_cnt), c_fwd ? vecs[i].cnt_f : vecs[i].cnt_n);
            check_model();
            tick();
        end

        // ---------------- async reset mid-stall ----------------
        do_reset();
        run_cycle(mk(1,1,4'd7,0,0,1,4'd3,1,0,0));       // LW r3
        drive(mk(1,1,4'd3,0,0,1,4'd8,0,0,0));           // reads r3
        chk("pre_reset_stall", 32'(a_stall), 1);
        #2 reset = 1'b1;
        mdl_reset();
        #1;
        chk("async_reset_stall", 32'(a_stall), 0);
        chk("async_reset_fwd1",  32'(a_fwd1),  0);
        chk("async_reset_cnt",   32'(a_cnt),   0);
        check_model();
        @(negedge clk);
        reset = 1'b0;

        // ---------------- r0 hardwired and counter saturation ----------------
        do_reset();
        run_cycle(mk(1,0,0,0,0,1,4'd0,0,0,0));          // ADD r0
        drive(mk(1,1,4'd0,1,4'd0,1,4'd9,0,0,0));        // reads r0 twice
        chk("r0_b_stall", 32'(b_stall), 0);
        chk("r0_b_fwd1",  32'(b_fwd1),  0);
        chk("r0_b_fwd2",  32'(b_fwd2),  0);
        check_model();
        tick();
        for (int p = 0; p < 4; p++) begin
            run_cycle(mk(1,0,0,0,0,1,4'd5,1,0,0));      // LW r5
            repeat (3) run_cycle(mk(1,1,4'd5,0,0,0,0,0,0,0));
        end
        drive(nop);
        chk("b_cnt_saturated", 32'(b_cnt), 3);
        tick();

        // ---------------- randomized against the model ----------------
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            in_t x;
            x.valid = ($urandom_range(0, 9) < 8);
            x.re1   = $urandom_range(0, 1);
            x.rs1   = 4'($urandom_range(0, 3));
            x.re2   = $urandom_range(0, 1);
            x.rs2   = 4'($urandom_range(0, 3));
            x.we    = $urandom_range(0, 1);
            x.ws    = 4'($urandom_range(0, 3));
            x.ld    = ($urandom_range(0, 2) == 0);
            x.fl    = ($urandom_range(0, 9) == 0);
            x.mw    = ($urandom_range(0, 9) == 0);
            run_cycle(x);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire
